// File: rtl/maf_pkg.sv
// Shared mode codes and default widths for the MAF alignment-shift datapath.
package maf_pkg;

    localparam logic [2:0] MODE_FUSED = 3'b000;
    localparam logic [2:0] MODE_SPLIT = 3'b001;

    localparam int unsigned DEF_LANES = 2;
    localparam int unsigned DEF_EW    = 7;
    localparam int unsigned DEF_SHW   = 6;

endpackage

// File: rtl/asc_lane_calc.sv
// Combinational clamp and dominance for one exponent difference.
// diff = EA+EB-EC at W+2 bits; shift = diff-OFF clamped to [0, MAX]; d when diff >= DB.
module asc_lane_calc #(
    parameter int unsigned W   = 7,
    parameter int unsigned OFF = 1,
    parameter int unsigned MAX = 37,
    parameter int unsigned DB  = 15,
    parameter int unsigned OW  = 6
) (
    input  logic signed [W+1:0] diff,
    output logic [OW-1:0]       sh,
    output logic                d,
    output logic                sat
);

    localparam logic signed [W+1:0] OFF_S = (W+2)'(OFF);
    localparam logic signed [W+1:0] MAX_S = (W+2)'(MAX);
    localparam logic signed [W+1:0] DB_S  = (W+2)'(DB);

    logic signed [W+1:0] raw;

    always_comb begin
        raw = diff - OFF_S;
        sh  = '0;
        sat = 1'b0;
        d   = (diff >= DB_S);
        if (raw[W+1]) begin
            sh = '0;
        end else if (raw > MAX_S) begin
            sh  = OW'(MAX_S);
            sat = 1'b1;
        end else begin
            sh = OW'(raw);
        end
    end

endmodule

// File: rtl/asc_pipe.sv
// Two-stage alignment-shift calculator with valid/ready flow control.
// S1 registers mode and raw differences; S2 clamps, muxes on mode and holds the outputs.
module asc_pipe
    import maf_pkg::*;
#(
    parameter int unsigned LANES    = DEF_LANES,
    parameter int unsigned EW       = DEF_EW,
    parameter int unsigned SHW      = DEF_SHW,
    parameter int unsigned SH_OFF   = 1,
    parameter int unsigned MAX_SH   = 37,
    parameter int unsigned D_BIAS   = 15,
    parameter int unsigned F_SH_OFF = 100,
    parameter int unsigned F_MAX_SH = 76,
    parameter int unsigned F_D_BIAS = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             cont,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*EW-1:0]    E_A,
    input  logic [LANES*EW-1:0]    E_B,
    input  logic [LANES*EW-1:0]    E_C,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*SHW-1:0]   sh_num,
    output logic [LANES-1:0]       d,
    output logic [LANES-1:0]       sat,
    output logic                   mode_err
);

    localparam int unsigned FEW = LANES * EW;
    localparam int unsigned LDW = EW + 2;
    localparam int unsigned FDW = FEW + 2;
    localparam int unsigned OW  = LANES * SHW;

    function automatic logic [LDW-1:0] sx_lane(input logic [EW-1:0] x);
        return {{2{x[EW-1]}}, x};
    endfunction

    function automatic logic [FDW-1:0] sx_fused(input logic [FEW-1:0] x);
        return {{2{x[FEW-1]}}, x};
    endfunction

    logic                        s1_valid;
    logic [2:0]                  s1_mode;
    logic [LANES-1:0][LDW-1:0]   s1_ldiff;
    logic [FDW-1:0]              s1_fdiff;

    logic                        s2_adv_c;
    logic                        s1_adv_c;
    logic [LANES-1:0][LDW-1:0]   ldiff_c;
    logic [FDW-1:0]              fdiff_c;

    logic [OW-1:0]               lsh_c;
    logic [LANES-1:0]            ld_c;
    logic [LANES-1:0]            lsat_c;
    logic [OW-1:0]               fsh_c;
    logic                        fd_c;
    logic                        fsat_c;

    logic [OW-1:0]               nsh_c;
    logic [LANES-1:0]            nd_c;
    logic [LANES-1:0]            nsat_c;
    logic                        nerr_c;

    // Bubbles collapse: a stage advances whenever the one after it can take its contents.
    always_comb begin
        s2_adv_c = !out_valid || out_ready;
        s1_adv_c = !s1_valid || s2_adv_c;
        in_ready = s1_adv_c;
    end

    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            ldiff_c[i] = sx_lane(E_A[i*EW +: EW]) + sx_lane(E_B[i*EW +: EW])
                       - sx_lane(E_C[i*EW +: EW]);
        end
        fdiff_c = sx_fused(E_A) + sx_fused(E_B) - sx_fused(E_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_FUSED;
            s1_ldiff <= '0;
            s1_fdiff <= '0;
        end else if (s1_adv_c) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode  <= cont;
                s1_ldiff <= ldiff_c;
                s1_fdiff <= fdiff_c;
            end
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        asc_lane_calc #(
            .W   (EW),
            .OFF (SH_OFF),
            .MAX (MAX_SH),
            .DB  (D_BIAS),
            .OW  (SHW)
        ) u_lane (
            .diff (s1_ldiff[g]),
            .sh   (lsh_c[g*SHW +: SHW]),
            .d    (ld_c[g]),
            .sat  (lsat_c[g])
        );
    end

    asc_lane_calc #(
        .W   (FEW),
        .OFF (F_SH_OFF),
        .MAX (F_MAX_SH),
        .DB  (F_D_BIAS),
        .OW  (OW)
    ) u_fused (
        .diff (s1_fdiff),
        .sh   (fsh_c),
        .d    (fd_c),
        .sat  (fsat_c)
    );

    // Reserved codes pass through as a zero result flagged with mode_err.
    always_comb begin
        nsh_c  = '0;
        nd_c   = '0;
        nsat_c = '0;
        nerr_c = 1'b0;
        case (s1_mode)
            MODE_FUSED: begin
                nsh_c  = fsh_c;
                nd_c   = LANES'(fd_c);
                nsat_c = LANES'(fsat_c);
            end
            MODE_SPLIT: begin
                nsh_c  = lsh_c;
                nd_c   = ld_c;
                nsat_c = lsat_c;
            end
            default: nerr_c = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sh_num    <= '0;
            d         <= '0;
            sat       <= '0;
            mode_err  <= 1'b0;
        end else if (s2_adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sh_num   <= nsh_c;
                d        <= nd_c;
                sat      <= nsat_c;
                mode_err <= nerr_c;
            end
        end
    end

endmodule

// File: tb/tb_asc_pipe.sv
// Directed bench for asc_pipe: hand-computed results checked in order at the output handshake.
module tb_asc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cont;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] E_A, E_B, E_C;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] sh_num;
    logic [1:0]  d;
    logic [1:0]  sat;
    logic        mode_err;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] expq[$];
    string       tagq[$];

    asc_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .cont      (cont),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .E_A       (E_A),
        .E_B       (E_B),
        .E_C       (E_C),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sh_num    (sh_num),
        .d         (d),
        .sat       (sat),
        .mode_err  (mode_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] pk(input int l1, input int l0);
        logic [6:0] h;
        logic [6:0] l;
        h = 7'(l1);
        l = 7'(l0);
        return {h, l};
    endfunction

    function automatic logic [31:0] ex(input logic err, input logic [1:0] s,
                                       input logic [1:0] dd, input logic [11:0] sh);
        return 32'({err, s, dd, sh});
    endfunction

    function automatic logic [31:0] obs();
        return 32'({mode_err, sat, d, sh_num});
    endfunction

    // Offer one beat; the expected result is queued only when the handshake happens.
    task automatic send(input logic [2:0] m, input logic [13:0] a, input logic [13:0] b,
                        input logic [13:0] c, input logic [31:0] e, input string tag);
        logic rdy;
        int   n;
        cont     = m;
        E_A      = a;
        E_B      = b;
        E_C      = c;
        in_valid = 1'b1;
        n        = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 20);
        if (rdy) begin
            expq.push_back(e);
            tagq.push_back(tag);
        end else begin
            chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
        end
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("extra_beat", 32'd1, 32'd0);
            end else begin
                chk(tagq.pop_front(), obs(), expq.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] EX_S1 = ex(1'b0, 2'b00, 2'b01, 12'd24);

    initial begin
        rst       = 1'b1;
        cont      = 3'b000;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        E_A       = '0;
        E_B       = '0;
        E_C       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", obs(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Split lanes, clamp low/high, and extreme signed inputs.
        send(3'b001, pk(1, 10), pk(1, 20), pk(20, 5), EX_S1, "split_basic");
        send(3'b001, pk(-5, 40), pk(3, 30), pk(-2, 0), ex(1'b0, 2'b01, 2'b01, 12'd37), "split_sat");
        send(3'b001, pk(20, 30), pk(19, 8), pk(0, 0), ex(1'b0, 2'b10, 2'b11, 12'd2405), "split_max_edge");
        send(3'b001, pk(7, 10), pk(7, 5), pk(0, 0), ex(1'b0, 2'b00, 2'b01, 12'd846), "split_d_edge");
        send(3'b001, pk(63, -64), pk(63, -64), pk(-64, 63), ex(1'b0, 2'b10, 2'b10, 12'd2368), "split_extreme");

        // Fused mode, switching straight from split.
        send(3'b000, 14'd200, 14'd100, 14'd150, ex(1'b0, 2'b00, 2'b01, 12'd50), "fused_basic");
        send(3'b000, 14'd300, 14'd300, 14'd0, ex(1'b0, 2'b01, 2'b01, 12'd76), "fused_sat");
        send(3'b000, 14'd10, 14'd10, 14'd0, ex(1'b0, 2'b00, 2'b00, 12'd0), "fused_neg");
        send(3'b000, 14'd100, 14'd76, 14'd0, ex(1'b0, 2'b00, 2'b01, 12'd76), "fused_max_edge");
        send(3'b000, 14'd100, 14'd77, 14'd0, ex(1'b0, 2'b01, 2'b01, 12'd76), "fused_max_over");
        send(3'b000, 14'd100, 14'd27, 14'd0, ex(1'b0, 2'b00, 2'b01, 12'd27), "fused_d_edge");
        send(3'b000, 14'd100, 14'd26, 14'd0, ex(1'b0, 2'b00, 2'b00, 12'd26), "fused_d_below");
        send(3'b000, 14'd8191, 14'd8191, 14'h2000, ex(1'b0, 2'b01, 2'b01, 12'd76), "fused_extreme");

        // Reserved code sandwiched between split beats.
        send(3'b001, pk(1, 10), pk(1, 20), pk(20, 5), EX_S1, "res_prev");
        send(3'b111, pk(1, 10), pk(1, 20), pk(20, 5), ex(1'b1, 2'b00, 2'b00, 12'd0), "res_111");
        send(3'b010, 14'd300, 14'd300, 14'd0, ex(1'b1, 2'b00, 2'b00, 12'd0), "res_010");
        send(3'b001, pk(-5, 40), pk(3, 30), pk(-2, 0), ex(1'b0, 2'b01, 2'b01, 12'd37), "res_next");
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two beats absorbed, third held off, outputs frozen.
        out_ready = 1'b0;
        send(3'b001, pk(1, 10), pk(1, 20), pk(20, 5), EX_S1, "bp_b1");
        send(3'b000, 14'd200, 14'd100, 14'd150, ex(1'b0, 2'b00, 2'b01, 12'd50), "bp_b2");
        cont     = 3'b001;
        E_A      = pk(20, 30);
        E_B      = pk(19, 8);
        E_C      = pk(0, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_hold", obs(), EX_S1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(3'b001, pk(20, 30), pk(19, 8), pk(0, 0), ex(1'b0, 2'b10, 2'b11, 12'd2405), "bp_b3");
        @(negedge clk);
        chk("bp_drain_b2", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_drain_b3", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_drain_idle", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset with two beats in flight discards both.
        send(3'b001, pk(1, 10), pk(1, 20), pk(20, 5), EX_S1, "rst_b1");
        send(3'b000, 14'd300, 14'd300, 14'd0, ex(1'b0, 2'b01, 2'b01, 12'd76), "rst_b2");
        rst = 1'b1;
        expq.delete();
        tagq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_flush_valid", 32'(out_valid), 32'd0);
        end
        chk("rst_flush_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send(3'b001, pk(-5, 40), pk(3, 30), pk(-2, 0), ex(1'b0, 2'b01, 2'b01, 12'd37), "post_rst");

        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
